// File: rtl/uartmm_fifo.sv
// uartmm_fifo: memory-mapped UART bridge on CPU port B with RX/TX byte FIFOs.
// Register window BASE_ADDR..BASE_ADDR+3 (+4 with CTRL when UARTMM_IRQ_EN is defined).
// Optional feature macro: UARTMM_IRQ_EN (CTRL register and registered irq output).

// Byte FIFO; push/pop arrive already qualified by the parent.
module uartmm_fifo_buf #(
  parameter int LOG2 = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [7:0]      din,
  output logic [7:0]      head,
  output logic [LOG2:0]   count,
  output logic            empty,
  output logic            full
);
  localparam int DEPTH = 1 << LOG2;

  logic [7:0]      mem [DEPTH];
  logic [LOG2-1:0] wptr, rptr;

  assign empty = (count == '0);
  // count never exceeds DEPTH, so its top bit alone marks full
  assign full  = count[LOG2];
  assign head  = empty ? 8'h00 : mem[rptr];

  // Storage array, no reset needed: contents are only visible through count
  always_ff @(posedge clk)
    if (push) mem[wptr] <= din;

  // Pointers wrap naturally at DEPTH; count tracks occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module uartmm_fifo #(
  parameter logic [31:0] BASE_ADDR     = 32'd65537,
  parameter int          RX_DEPTH_LOG2 = 4,
  parameter int          TX_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  uart_din,
  input  logic        uart_valid,
  input  logic        uart_busy,
  output logic [7:0]  uart_dout,
  output logic        uart_wr,
  input  logic [31:0] addr_b,
  input  logic [31:0] data_b_in,
  input  logic [31:0] data_b_we,
  input  logic        data_b_re,
  output logic [31:0] data_b,
  output logic        strobe_b,
  output logic        irq
);
`ifdef UARTMM_IRQ_EN
  localparam logic [31:0] LAST_OFF = 32'd4;
`else
  localparam logic [31:0] LAST_OFF = 32'd3;
`endif

  logic [31:0] off;
  logic        hit, wr;
  logic        sel_status, sel_txrdy, sel_data, sel_count;
  logic        rx_push, rx_pop, rx_empty, rx_full;
  logic        tx_push, tx_issue, tx_empty, tx_full;
  logic [7:0]  rx_head, tx_head;
  logic [RX_DEPTH_LOG2:0] rx_cnt;
  logic [TX_DEPTH_LOG2:0] tx_cnt;
  logic        rx_ovf, tx_ovf;
  logic        clr_rx_ovf, clr_tx_ovf;
  logic        unused_in;

  assign unused_in = ^data_b_in[31:8];

  // Address decode; the >= test keeps addresses below BASE from wrapping into the window
  assign off        = addr_b - BASE_ADDR;
  assign hit        = (addr_b >= BASE_ADDR) && (off <= LAST_OFF);
  assign strobe_b   = hit;
  assign wr         = |data_b_we;
  assign sel_status = hit && (off == 32'd0);
  assign sel_txrdy  = hit && (off == 32'd1);
  assign sel_data   = hit && (off == 32'd2);
  assign sel_count  = hit && (off == 32'd3);

  // A full FIFO still accepts a push when it pops in the same cycle
  assign rx_pop   = sel_data && data_b_re && !rx_empty;
  assign rx_push  = uart_valid && (!rx_full || rx_pop);
  assign tx_issue = !tx_empty && !uart_busy && !uart_wr;
  assign tx_push  = sel_data && wr && (!tx_full || tx_issue);

  assign clr_rx_ovf = sel_status && wr && data_b_in[1];
  assign clr_tx_ovf = sel_status && wr && data_b_in[5];

  uartmm_fifo_buf #(.LOG2(RX_DEPTH_LOG2)) u_rx (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(uart_din),
    .head(rx_head), .count(rx_cnt), .empty(rx_empty), .full(rx_full)
  );

  uartmm_fifo_buf #(.LOG2(TX_DEPTH_LOG2)) u_tx (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_issue), .din(data_b_in[7:0]),
    .head(tx_head), .count(tx_cnt), .empty(tx_empty), .full(tx_full)
  );

  // Sticky overflow flags; a new overflow wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_ovf <= 1'b0;
      tx_ovf <= 1'b0;
    end else begin
      rx_ovf <= (rx_ovf && !clr_rx_ovf) || (uart_valid && !rx_push);
      tx_ovf <= (tx_ovf && !clr_tx_ovf) || (sel_data && wr && !tx_push);
    end
  end

  // TX issue: one-cycle uart_wr pulse, the low cycle after it spaces bytes by two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      uart_wr   <= 1'b0;
      uart_dout <= 8'h00;
    end else begin
      uart_wr <= tx_issue;
      if (tx_issue) uart_dout <= tx_head;
    end
  end

`ifdef UARTMM_IRQ_EN
  logic [1:0] ctrl;
  logic       sel_ctrl;

  assign sel_ctrl = hit && (off == 32'd4);

  // CTRL register and registered interrupt request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl <= 2'b00;
      irq  <= 1'b0;
    end else begin
      if (sel_ctrl && wr) ctrl <= data_b_in[1:0];
      irq <= (ctrl[0] && !rx_empty) || (ctrl[1] && tx_empty) || rx_ovf || tx_ovf;
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Read mux, combinational from addr_b; undecoded addresses read zero
  always_comb begin
    data_b = 32'h0;
    if (sel_status)
      data_b[5:0] = {tx_ovf, irq, tx_empty, tx_full, rx_ovf, !rx_empty};
    else if (sel_txrdy)
      data_b[0] = !tx_full;
    else if (sel_data)
      data_b[7:0] = rx_head;
    else if (sel_count) begin
      data_b[15:0]  = 16'(rx_cnt);
      data_b[31:16] = 16'(tx_cnt);
    end
`ifdef UARTMM_IRQ_EN
    else if (sel_ctrl)
      data_b[1:0] = ctrl;
`endif
  end
endmodule

// File: tb/tb_uartmm_fifo.sv
// Directed self-checking bench for uartmm_fifo (default parameters, depth 16).
module tb_uartmm_fifo;
  localparam logic [31:0] BASE = 32'd65537;
`ifdef UARTMM_IRQ_EN
  localparam logic [31:0] IRQB = 32'h10;
`else
  localparam logic [31:0] IRQB = 32'h00;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  uart_din = 8'h00;
  logic        uart_valid = 1'b0;
  logic        uart_busy = 1'b0;
  logic [7:0]  uart_dout;
  logic        uart_wr;
  logic [31:0] addr_b = 32'h0;
  logic [31:0] data_b_in = 32'h0;
  logic [31:0] data_b_we = 32'h0;
  logic        data_b_re = 1'b0;
  logic [31:0] data_b;
  logic        strobe_b;
  logic        irq;

  int checks = 0;
  int errors = 0;

  uartmm_fifo dut (
    .clk(clk), .rst(rst), .uart_din(uart_din), .uart_valid(uart_valid),
    .uart_busy(uart_busy), .uart_dout(uart_dout), .uart_wr(uart_wr),
    .addr_b(addr_b), .data_b_in(data_b_in), .data_b_we(data_b_we),
    .data_b_re(data_b_re), .data_b(data_b), .strobe_b(strobe_b), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk);
    uart_din = b; uart_valid = 1'b1;
    @(posedge clk); #1;
    uart_valid = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    addr_b = a; data_b_in = v; data_b_we = 32'hF;
    @(posedge clk); #1;
    data_b_we = 32'h0; addr_b = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, input logic pop, output logic [31:0] d, output logic s);
    @(negedge clk);
    addr_b = a; data_b_re = pop;
    #1;
    d = data_b; s = strobe_b;
    @(posedge clk); #1;
    data_b_re = 1'b0; addr_b = 32'h0;
  endtask

  logic [31:0] d;
  logic        s;
  int          npulse, t1, t2;
  logic [7:0]  b1, b2;

  initial begin
    // 1: reset state, then reset asserted during a uart_wr pulse
    idle(3);
    rd(BASE + 0, 1'b0, d, s);
    chk("reset_status", d, 32'h08);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    @(negedge clk) rst = 1'b1;
    rx_byte(8'h33);
    wr(BASE + 2, 32'h77);
    wr(BASE + 2, 32'h78);
    chk("pre_rst_uart_wr", {31'b0, uart_wr}, 32'h1);
    chk("pre_rst_dout", {24'b0, uart_dout}, 32'h77);
    addr_b = BASE + 3; #1;
    chk("pre_rst_count", data_b, 32'h0001_0001);
    rst = 1'b0; #1;
    chk("rst_uart_wr_drop", {31'b0, uart_wr}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_count", data_b, 32'h0);
    chk("rst_dout", {24'b0, uart_dout}, 32'h0);
    @(negedge clk) rst = 1'b1; addr_b = 32'h0;

    // 2: RX fill past depth, then drain
    for (int i = 1; i <= 17; i++) rx_byte(8'(i));
    rd(BASE + 3, 1'b0, d, s);
    chk("rx_fill_count", d, 32'h10);
    rd(BASE + 0, 1'b0, d, s);
    chk("rx_fill_status", d, 32'h0B | IRQB);
    for (int i = 1; i <= 16; i++) begin
      rd(BASE + 2, 1'b1, d, s);
      chk($sformatf("rx_pop_%0d", i), d, 32'(i));
    end
    rd(BASE + 2, 1'b1, d, s);
    chk("rx_empty_data", d, 32'h0);
    rd(BASE + 0, 1'b0, d, s);
    chk("rx_drained_status", d, 32'h0A | IRQB);
    wr(BASE + 0, 32'h22);
    idle(1);
    rd(BASE + 0, 1'b0, d, s);
    chk("ovf_cleared_status", d, 32'h08);

    // 3: TX held off by busy, then two spaced pulses
    @(negedge clk) uart_busy = 1'b1;
    wr(BASE + 2, 32'h41);
    wr(BASE + 2, 32'h42);
    npulse = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (uart_wr) npulse++;
    end
    chk("busy_no_wr", 32'(npulse), 32'h0);
    rd(BASE + 1, 1'b0, d, s);
    chk("txrdy", d, 32'h1);
    @(negedge clk) uart_busy = 1'b0;
    npulse = 0; t1 = 0; t2 = 0; b1 = 8'h0; b2 = 8'h0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (uart_wr) begin
        npulse++;
        if (npulse == 1) begin t1 = c; b1 = uart_dout; end
        else if (npulse == 2) begin t2 = c; b2 = uart_dout; end
      end
    end
    chk("tx_pulses", 32'(npulse), 32'h2);
    chk("tx_byte0", {24'b0, b1}, 32'h41);
    chk("tx_byte1", {24'b0, b2}, 32'h42);
    chk("tx_spacing", {31'b0, (t2 - t1) >= 2}, 32'h1);

    // 4: RX full: set-wins on sticky clear, then simultaneous push/pop
    for (int i = 0; i < 16; i++) rx_byte(8'h60 + 8'(i));
    @(negedge clk);
    addr_b = BASE + 0; data_b_in = 32'h22; data_b_we = 32'hF;
    uart_valid = 1'b1; uart_din = 8'hEE;
    @(posedge clk); #1;
    uart_valid = 1'b0; data_b_we = 32'h0; addr_b = 32'h0;
    idle(1);
    rd(BASE + 0, 1'b0, d, s);
    chk("set_wins_status", d, 32'h0B | IRQB);
    wr(BASE + 0, 32'h02);
    idle(1);
    rd(BASE + 0, 1'b0, d, s);
    chk("full_clr_status", d, 32'h09);
    @(negedge clk);
    addr_b = BASE + 2; data_b_re = 1'b1; uart_valid = 1'b1; uart_din = 8'h55;
    #1 d = data_b;
    @(posedge clk); #1;
    data_b_re = 1'b0; uart_valid = 1'b0; addr_b = 32'h0;
    chk("simul_data", d, 32'h60);
    rd(BASE + 3, 1'b0, d, s);
    chk("simul_count", d, 32'h10);
    rd(BASE + 0, 1'b0, d, s);
    chk("simul_no_ovf", d, 32'h09);
    for (int i = 1; i < 16; i++) begin
      rd(BASE + 2, 1'b1, d, s);
      chk($sformatf("simul_pop_%0d", i), d, 32'h60 + 32'(i));
    end
    rd(BASE + 2, 1'b1, d, s);
    chk("simul_last_55", d, 32'h55);
    rd(BASE + 3, 1'b0, d, s);
    chk("simul_empty_count", d, 32'h0);

    // 5: TX overflow and sticky clear
    @(negedge clk) uart_busy = 1'b1;
    for (int i = 0; i < 17; i++) wr(BASE + 2, 32'hA0 + 32'(i));
    idle(1);
    rd(BASE + 0, 1'b0, d, s);
    chk("tx_ovf_status", d, 32'h24 | IRQB);
    rd(BASE + 1, 1'b0, d, s);
    chk("txrdy_full", d, 32'h0);
    rd(BASE + 3, 1'b0, d, s);
    chk("tx_full_count", d, 32'h0010_0000);
    wr(BASE + 0, 32'h22);
    idle(1);
    rd(BASE + 0, 1'b0, d, s);
    chk("tx_clr_status", d, 32'h04);
    @(negedge clk) uart_busy = 1'b0;
    idle(40);
    rd(BASE + 3, 1'b0, d, s);
    chk("tx_drain_count", d, 32'h0);
    rd(BASE + 0, 1'b0, d, s);
    chk("tx_drain_status", d, 32'h08);

    // Undecoded neighbours of the window
    rd(BASE - 1, 1'b0, d, s);
    chk("below_strobe", {31'b0, s}, 32'h0);
    chk("below_data", d, 32'h0);
    rd(BASE + 5, 1'b0, d, s);
    chk("above_strobe", {31'b0, s}, 32'h0);
    rd(BASE + 0, 1'b0, d, s);
    chk("base_strobe", {31'b0, s}, 32'h1);

    // 6: interrupt
`ifdef UARTMM_IRQ_EN
    wr(BASE + 4, 32'h1);
    rd(BASE + 4, 1'b0, d, s);
    chk("ctrl_readback", d, 32'h1);
    chk("ctrl_strobe", {31'b0, s}, 32'h1);
    rx_byte(8'h99);
    chk("irq_same_edge", {31'b0, irq}, 32'h0);
    idle(1);
    chk("irq_high", {31'b0, irq}, 32'h1);
    rd(BASE + 2, 1'b1, d, s);
    chk("irq_pop_data", d, 32'h99);
    idle(1);
    chk("irq_low", {31'b0, irq}, 32'h0);
`else
    wr(BASE + 4, 32'h1);
    rx_byte(8'h99);
    idle(2);
    chk("irq_tied", {31'b0, irq}, 32'h0);
    rd(BASE + 4, 1'b0, d, s);
    chk("ctrl_strobe", {31'b0, s}, 32'h0);
    chk("ctrl_data", d, 32'h0);
    rd(BASE + 0, 1'b0, d, s);
    chk("status_no_irq", d, 32'h09);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
